// File: rtl/uart_rx_ctrl_fsm_pkg.sv
// UART receive frame sequencer: shared states, widths and stage-enable decode.
// Used by the frame FSM and its edge/bit counter.
package uart_rx_ctrl_fsm_pkg;

  localparam int BIT_CNT_W    = 4;
  localparam int PRESCALE_MIN = 4;
  localparam int PRESCALE_RST = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } state_e;

  typedef struct packed {
    logic sample;
    logic start;
    logic deser;
    logic par;
    logic stop;
  } en_t;

  function automatic en_t stage_en(state_e s);
    en_t e;
    e        = '0;
    e.sample = s inside {START, DATA, PARITY, STOP};
    e.start  = (s == START);
    e.deser  = (s == DATA);
    e.par    = (s == PARITY);
    e.stop   = (s == STOP);
    return e;
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_fsm_edge_bit_cnt.sv
// Oversampling edge counter and bit index counter.
// Clear wins over preload, preload wins over counting.
module uart_rx_edge_bit_cnt
  import uart_rx_ctrl_fsm_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  clr,
  input  logic                  load1,
  input  logic                  run,
  input  logic [PRESCALE_W-1:0] ps_m1,
  output logic [PRESCALE_W-1:0] Edge_Cnt,
  output logic [BIT_CNT_W-1:0]  Bit_Cnt,
  output logic                  eob
);

  assign eob = (Edge_Cnt == ps_m1);

  always_ff @(posedge CLK) begin
    if (!RSTn || clr) begin
      Edge_Cnt <= '0;
      Bit_Cnt  <= '0;
    end else if (load1) begin
      Edge_Cnt <= PRESCALE_W'(1);
      Bit_Cnt  <= '0;
    end else if (run) begin
      if (eob) begin
        Edge_Cnt <= '0;
        Bit_Cnt  <= Bit_Cnt + 1'b1;
      end else begin
        Edge_Cnt <= Edge_Cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_ctrl_fsm.sv
// UART receive frame sequencer: start detect, per-bit checker enables,
// error-driven abort and one-cycle frame result pulses.
module uart_rx_ctrl_fsm
  import uart_rx_ctrl_fsm_pkg::*;
#(
  parameter int PRESCALE_W = 6,
  parameter int DATA_W     = 8
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  Start_error,
  input  logic                  Parity_error,
  input  logic                  Stop_error,
  output logic [PRESCALE_W-1:0] Edge_Cnt,
  output logic [BIT_CNT_W-1:0]  Bit_Cnt,
  output logic                  Sample_En,
  output logic                  Start_En,
  output logic                  Deser_En,
  output logic                  Par_Chk_En,
  output logic                  Stop_En,
  output logic                  Data_Valid,
  output logic                  Par_Err,
  output logic                  Frame_Err
);

  state_e                state;
  state_e                nxt;
  en_t                   en_q;
  logic [PRESCALE_W-1:0] ps_q;
  logic                  pe_q;
  logic                  clr;
  logic                  load1;
  logic                  run;
  logic                  eob;
  logic                  take_cfg;
  logic                  dv_n;
  logic                  pe_n;
  logic                  fe_n;
  logic                  last_data;

  localparam logic [PRESCALE_W-1:0] PS_MIN = PRESCALE_W'(PRESCALE_MIN);

  assign last_data = (Bit_Cnt == BIT_CNT_W'(DATA_W));

  uart_rx_edge_bit_cnt #(
    .PRESCALE_W(PRESCALE_W)
  ) u_cnt (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .clr     (clr),
    .load1   (load1),
    .run     (run),
    .ps_m1   (ps_q - 1'b1),
    .Edge_Cnt(Edge_Cnt),
    .Bit_Cnt (Bit_Cnt),
    .eob     (eob)
  );

  always_comb begin
    nxt      = state;
    clr      = 1'b0;
    load1    = 1'b0;
    run      = 1'b0;
    take_cfg = 1'b0;
    dv_n     = 1'b0;
    pe_n     = 1'b0;
    fe_n     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!RX_IN) begin
          nxt      = START;
          clr      = 1'b1;
          take_cfg = 1'b1;
        end
      end
      START: begin
        run = 1'b1;
        if (eob) begin
          if (Start_error) begin
            nxt = IDLE;
            clr = 1'b1;
          end else begin
            nxt = DATA;
          end
        end
      end
      DATA: begin
        run = 1'b1;
        if (eob && last_data)
          nxt = pe_q ? PARITY : STOP;
      end
      PARITY: begin
        run = 1'b1;
        if (eob) begin
          if (Parity_error) begin
            nxt  = IDLE;
            clr  = 1'b1;
            pe_n = 1'b1;
          end else begin
            nxt = STOP;
          end
        end
      end
      STOP: begin
        run = 1'b1;
        if (eob) begin
          clr = 1'b1;
          if (Stop_error) begin
            nxt  = IDLE;
            fe_n = 1'b1;
          end else begin
            nxt  = DONE;
            dv_n = 1'b1;
          end
        end
      end
      DONE: begin
        // Preload 1 so a start edge seen here keeps bit timing aligned.
        if (!RX_IN) begin
          nxt      = START;
          load1    = 1'b1;
          take_cfg = 1'b1;
        end else begin
          nxt = IDLE;
          clr = 1'b1;
        end
      end
      default: begin
        nxt = IDLE;
        clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state      <= IDLE;
      en_q       <= '0;
      ps_q       <= PRESCALE_W'(PRESCALE_RST);
      pe_q       <= 1'b0;
      Data_Valid <= 1'b0;
      Par_Err    <= 1'b0;
      Frame_Err  <= 1'b0;
    end else begin
      state      <= nxt;
      en_q       <= stage_en(nxt);
      Data_Valid <= dv_n;
      Par_Err    <= pe_n;
      Frame_Err  <= fe_n;
      if (take_cfg) begin
        ps_q <= (Prescale < PS_MIN) ? PS_MIN : Prescale;
        pe_q <= PAR_EN;
      end
    end
  end

  assign Sample_En  = en_q.sample;
  assign Start_En   = en_q.start;
  assign Deser_En   = en_q.deser;
  assign Par_Chk_En = en_q.par;
  assign Stop_En    = en_q.stop;

endmodule

// File: tb/tb_uart_rx_ctrl_fsm.sv
// Bench for the UART frame sequencer: directed frame table, corner sequences
// and random frames against a per-cycle frame timing model.
module tb_uart_rx_ctrl_fsm;

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic       RX_IN = 1'b1;
  logic [5:0] Prescale = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       Start_error = 1'b0;
  logic       Parity_error = 1'b0;
  logic       Stop_error = 1'b0;
  logic [5:0] Edge_Cnt;
  logic [3:0] Bit_Cnt;
  logic       Sample_En, Start_En, Deser_En, Par_Chk_En, Stop_En;
  logic       Data_Valid, Par_Err, Frame_Err;

  uart_rx_ctrl_fsm dut (
    .CLK(CLK), .RSTn(RSTn), .RX_IN(RX_IN), .Prescale(Prescale),
    .PAR_EN(PAR_EN), .Start_error(Start_error),
    .Parity_error(Parity_error), .Stop_error(Stop_error),
    .Edge_Cnt(Edge_Cnt), .Bit_Cnt(Bit_Cnt), .Sample_En(Sample_En),
    .Start_En(Start_En), .Deser_En(Deser_En), .Par_Chk_En(Par_Chk_En),
    .Stop_En(Stop_En), .Data_Valid(Data_Valid), .Par_Err(Par_Err),
    .Frame_Err(Frame_Err)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int dv_q[$];

  typedef struct {
    int         ps;
    int         pe;
    int         se;
    int         pq;
    int         fe;
    int         dat;
    int         exp_end;
    logic [2:0] exp_pulse;
  } vec_t;

  function automatic logic [17:0] outv();
    return {Edge_Cnt, Bit_Cnt, Sample_En, Start_En, Deser_En,
            Par_Chk_En, Stop_En, Data_Valid, Par_Err, Frame_Err};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
    if (Data_Valid) dv_q.push_back(cyc);
  endtask

  task automatic chk(input string nm, input logic [17:0] got,
                     input logic [17:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  // Frame cycle n counts from the cycle the start edge is sampled (n=0).
  // Bit b occupies cycles b*ps+1 .. (b+1)*ps.
  function automatic logic [17:0] mexp(int n, int ps, int pe, int e_end,
                                       logic [2:0] pulse);
    int b, e;
    if (n >= e_end) return {15'd0, pulse};
    b = (n - 1) / ps;
    e = (n - 1) % ps;
    return {6'(e), 4'(b), 1'b1, (b == 0), (b >= 1 && b <= 8),
            (pe == 1 && b == 9), (b == 9 + pe), 3'b000};
  endfunction

  task automatic start_from_idle(input int n_idle, input int ps,
                                 input int pe);
    for (int i = 0; i <= n_idle; i++) begin
      tick();
      chk("idle", outv(), 18'd0);
      RX_IN        = (i == n_idle) ? 1'b0 : 1'b1;
      Prescale     = (i == n_idle) ? 6'(ps) : 6'($urandom);
      PAR_EN       = (i == n_idle) ? 1'(pe) : 1'($urandom);
      Start_error  = 1'($urandom);
      Parity_error = 1'($urandom);
      Stop_error   = 1'($urandom);
    end
  endtask

  task automatic frame(input int psd, input int pe, input int off,
                       input int se, input int pq, input int fe,
                       input int dat, input bit b2b, input int rst_at,
                       output int obs_end, output logic [2:0] obs_pulse);
    int ps, e_end, n, b;
    logic [2:0] pulse;
    logic [7:0] d;
    d = 8'(dat);
    ps = (psd < 4) ? 4 : psd;
    if (se != 0) begin
      e_end = ps + 1; pulse = 3'b000;
    end else if (pe != 0 && pq != 0) begin
      e_end = 10 * ps + 1; pulse = 3'b010;
    end else begin
      e_end = (10 + pe) * ps + 1;
      pulse = (fe != 0) ? 3'b001 : 3'b100;
    end
    obs_end = -1;
    obs_pulse = 3'b000;
    for (int k = 1; k <= e_end - off; k++) begin
      n = k + off;
      tick();
      if (obs_end < 0 && !Sample_En) begin
        obs_end = n;
        obs_pulse = {Data_Valid, Par_Err, Frame_Err};
      end
      chk("frame", outv(), mexp(n, ps, pe, e_end, pulse));
      if (rst_at == n) begin
        RSTn = 1'b0;
        RX_IN = 1'b1;
        return;
      end
      Start_error  = (n == ps) ? 1'(se) : 1'($urandom);
      Parity_error = (pe != 0 && n == 10 * ps) ? 1'(pq) : 1'($urandom);
      Stop_error   = (n == (10 + pe) * ps) ? 1'(fe) : 1'($urandom);
      Prescale     = 6'($urandom);
      PAR_EN       = 1'($urandom);
      if (n < e_end) begin
        b = (n - 1) / ps;
        if (b == 0) RX_IN = 1'b0;
        else if (b <= 8) RX_IN = d[b-1];
        else if (pe != 0 && b == 9) RX_IN = ^d;
        else RX_IN = 1'b1;
      end else if (b2b && pulse == 3'b100) begin
        RX_IN = 1'b0;
        Prescale = 6'(ps);
        PAR_EN = 1'(pe);
      end else begin
        RX_IN = 1'b1;
      end
    end
  endtask

  vec_t vt[8];

  initial begin
    int oe;
    logic [2:0] op;
    int off, ps, pe, se, pq, fe, want;

    vt[0] = '{8,  0, 0, 0, 0, 'hA5, 81,  3'b100};
    vt[1] = '{16, 1, 0, 1, 0, 'h3C, 161, 3'b010};
    vt[2] = '{8,  0, 1, 0, 0, 'h00, 9,   3'b000};
    vt[3] = '{8,  0, 0, 0, 1, 'h5A, 81,  3'b001};
    vt[4] = '{2,  0, 0, 0, 0, 'hFF, 41,  3'b100};
    vt[5] = '{16, 1, 0, 0, 0, 'h81, 177, 3'b100};
    vt[6] = '{32, 0, 0, 0, 0, 'h7E, 321, 3'b100};
    vt[7] = '{3,  1, 0, 0, 1, 'h11, 45,  3'b001};

    tick();
    chk("reset", outv(), 18'd0);
    tick();
    chk("reset2", outv(), 18'd0);
    RSTn = 1'b1;

    foreach (vt[i]) begin
      start_from_idle(2, vt[i].ps, vt[i].pe);
      frame(vt[i].ps, vt[i].pe, 0, vt[i].se, vt[i].pq, vt[i].fe,
            vt[i].dat, 1'b0, 0, oe, op);
      chk_int($sformatf("end_cyc%0d", i), oe, vt[i].exp_end);
      chk_int($sformatf("pulse%0d", i), int'(op), int'(vt[i].exp_pulse));
    end

    // Back-to-back frames: start edge sampled in the DONE cycle.
    dv_q.delete();
    start_from_idle(1, 8, 0);
    frame(8, 0, 0, 0, 0, 0, 'hA5, 1'b1, 0, oe, op);
    frame(8, 0, 1, 0, 0, 0, 'h5A, 1'b0, 0, oe, op);
    chk_int("b2b_count", dv_q.size(), 2);
    if (dv_q.size() == 2)
      chk_int("b2b_gap", dv_q[1] - dv_q[0], 80);

    // Reset in the middle of the data bits.
    start_from_idle(1, 8, 0);
    frame(8, 0, 0, 0, 0, 0, 'hC3, 1'b0, 30, oe, op);
    tick();
    chk("mid_rst", outv(), 18'd0);
    RSTn = 1'b1;
    start_from_idle(2, 8, 0);
    frame(8, 0, 0, 0, 0, 0, 'hC3, 1'b0, 0, oe, op);
    chk_int("after_rst_end", oe, 81);

    off = 0;
    ps = 8;
    pe = 0;
    for (int i = 0; i < 40; i++) begin
      if (off == 0) begin
        ps = ($urandom % 4 == 0) ? (($urandom % 2 == 0) ? 16 : 32)
                                 : 2 + int'($urandom % 15);
        pe = int'($urandom % 2);
        start_from_idle(int'($urandom % 4), ps, pe);
      end
      se = ($urandom % 6 == 0) ? 1 : 0;
      pq = ($urandom % 4 == 0) ? 1 : 0;
      fe = ($urandom % 5 == 0) ? 1 : 0;
      want = (i < 39 && $urandom % 3 == 0) ? 1 : 0;
      frame(ps, pe, off, se, pq, fe, int'($urandom), want != 0, 0,
            oe, op);
      off = (want != 0 && se == 0 && !(pe != 0 && pq != 0) && fe == 0)
            ? 1 : 0;
    end
    start_from_idle(3, 8, 0);
    RX_IN = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
